// File: rtl/mips_boot_loader.sv
// Boot loader for a small MIPS-style core: streams program words into
// instruction memory, pulses the PC initialisation, releases the processor
// and supervises it until it halts or runs out of cycle budget.
module mips_boot_loader #(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 10,
    parameter int                TMO_W   = 16,
    parameter logic [DATA_W-1:0] BOOT_PC = '0
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_init,
    output logic              cpu_run,
    input  logic              cpu_halted,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [TMO_W-1:0]  run_cycles
);

    // One extra bit so the counter can hold the full program depth.
    localparam int                CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [TMO_W-1:0]  RUN_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BOOT,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   word_cnt_reg;
    logic               mem_we_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [DATA_W-1:0]  mem_wdata_reg;
    logic               done_reg;
    logic               err_reg;
    logic [1:0]         err_code_reg;
    logic [TMO_W-1:0]   run_cycles_reg;

    logic               accept;
    logic               overflow;
    logic               write_ok;
    logic               start_ok;
    logic [TMO_W-1:0]   run_cycles_inc;
    logic               timeout;

    // A word is taken whenever the stream is valid while loading; the word
    // beyond the memory depth is taken but never written.
    assign accept         = (state_reg == S_LOAD) && ld_valid;
    assign overflow       = accept && (word_cnt_reg == DEPTH_CNT);
    assign write_ok       = accept && !overflow;
    assign start_ok       = start && ((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                                      (state_reg == S_ERR));
    assign run_cycles_inc = (run_cycles_reg == RUN_MAX) ? run_cycles_reg
                                                        : run_cycles_reg + TMO_W'(1);
    // Timeout fires on the cycle whose increment lands on the limit.
    assign timeout        = (run_cycles_inc == RUN_MAX);

    // State register
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; halt takes priority over timeout
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_next = S_LOAD;
            end
            S_LOAD: begin
                if (overflow)               state_next = S_ERR;
                else if (accept && ld_last) state_next = S_BOOT;
            end
            S_BOOT: state_next = S_RUN;
            S_RUN: begin
                if (cpu_halted)   state_next = S_DONE;
                else if (timeout) state_next = S_ERR;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        ld_ready = 1'b0;
        pc_load  = 1'b0;
        cpu_run  = 1'b0;
        case (state_reg)
            S_LOAD:  ld_ready = 1'b1;
            S_BOOT:  pc_load  = 1'b1;
            S_RUN:   cpu_run  = 1'b1;
            default: ;
        endcase
    end

    // Write port, word counter, run-cycle counter and status flags
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            word_cnt_reg   <= '0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            err_code_reg   <= 2'b00;
            run_cycles_reg <= '0;
        end else begin
            mem_we_reg <= write_ok;
            if (write_ok) begin
                mem_addr_reg  <= ld_addr;
                mem_wdata_reg <= ld_data;
            end

            if (start_ok) begin
                word_cnt_reg <= '0;
                done_reg     <= 1'b0;
                err_reg      <= 1'b0;
                err_code_reg <= 2'b00;
            end else if (write_ok) begin
                word_cnt_reg <= word_cnt_reg + CNT_W'(1);
            end

            if (overflow) begin
                err_reg      <= 1'b1;
                err_code_reg <= 2'b01;
            end

            if (state_reg == S_BOOT) begin
                run_cycles_reg <= '0;
            end

            if (state_reg == S_RUN) begin
                run_cycles_reg <= run_cycles_inc;
                if (cpu_halted) begin
                    done_reg <= 1'b1;
                end else if (timeout) begin
                    err_reg      <= 1'b1;
                    err_code_reg <= 2'b10;
                end
            end
        end
    end

    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign pc_init    = BOOT_PC;
    assign done       = done_reg;
    assign err        = err_reg;
    assign err_code   = err_code_reg;
    assign run_cycles = run_cycles_reg;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Self-checking bench for mips_boot_loader: a session-level reference model
// is compared against the DUT every cycle, plus literal end-of-scenario checks.
module tb_mips_boot_loader;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int TW    = 7;
    localparam int DEPTH = 8;
    localparam int MAXC  = 127;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_BOOT = 2;
    localparam int P_RUN  = 3;
    localparam int P_DONE = 4;
    localparam int P_ERR  = 5;

    logic          clk1 = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_last = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          pc_load;
    logic [DW-1:0] pc_init;
    logic          cpu_run;
    logic          cpu_halted = 1'b0;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [TW-1:0] run_cycles;

    int errors = 0;
    int checks = 0;
    int obs_writes = 0;
    int obs_pcloads = 0;

    // Reference model state (session view)
    int            m_phase = P_IDLE;
    int            m_words = 0;
    int            m_cycles = 0;
    bit            m_done = 1'b0;
    bit            m_err = 1'b0;
    logic [1:0]    m_code = 2'b00;
    bit            m_we = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;

    logic [AW-1:0] prog_addr [0:15];
    logic [DW-1:0] prog_data [0:15];

    mips_boot_loader #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .TMO_W  (TW),
        .BOOT_PC(32'h0000_0000)
    ) dut (
        .clk1      (clk1),
        .rst       (rst),
        .start     (start),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .pc_load   (pc_load),
        .pc_init   (pc_init),
        .cpu_run   (cpu_run),
        .cpu_halted(cpu_halted),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .run_cycles(run_cycles)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances one session step per clock, resets at once on rst
    initial begin
        forever begin
            @(posedge clk1 or posedge rst);
            if (rst) begin
                m_phase = P_IDLE; m_words = 0; m_cycles = 0;
                m_done = 1'b0; m_err = 1'b0; m_code = 2'b00; m_we = 1'b0;
            end else begin
                m_we = 1'b0;
                case (m_phase)
                    P_IDLE, P_DONE, P_ERR: begin
                        if (start) begin
                            m_phase = P_LOAD; m_done = 1'b0; m_err = 1'b0;
                            m_code = 2'b00; m_words = 0;
                        end
                    end
                    P_LOAD: begin
                        if (ld_valid) begin
                            m_words++;
                            if (m_words > DEPTH) begin
                                m_phase = P_ERR; m_err = 1'b1; m_code = 2'b01;
                            end else begin
                                m_we = 1'b1; m_waddr = ld_addr; m_wdata = ld_data;
                                if (ld_last) m_phase = P_BOOT;
                            end
                        end
                    end
                    P_BOOT: begin
                        m_phase = P_RUN; m_cycles = 0;
                    end
                    P_RUN: begin
                        if (m_cycles < MAXC) m_cycles++;
                        if (cpu_halted) begin
                            m_phase = P_DONE; m_done = 1'b1;
                        end else if (m_cycles == MAXC) begin
                            m_phase = P_ERR; m_err = 1'b1; m_code = 2'b10;
                        end
                    end
                    default: m_phase = P_IDLE;
                endcase
            end
        end
    end

    // Per-cycle comparison on the falling edge
    initial begin
        forever begin
            @(negedge clk1);
            chk("ld_ready",   64'(ld_ready),   64'(m_phase == P_LOAD));
            chk("pc_load",    64'(pc_load),    64'(m_phase == P_BOOT));
            chk("cpu_run",    64'(cpu_run),    64'(m_phase == P_RUN));
            chk("pc_init",    64'(pc_init),    64'(0));
            chk("done",       64'(done),       64'(m_done));
            chk("err",        64'(err),        64'(m_err));
            chk("err_code",   64'(err_code),   64'(m_code));
            chk("run_cycles", 64'(run_cycles), 64'(m_cycles));
            chk("mem_we",     64'(mem_we),     64'(m_we));
            if (m_we) begin
                chk("mem_addr",  64'(mem_addr),  64'(m_waddr));
                chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            end
            if (mem_we)  obs_writes++;
            if (pc_load) obs_pcloads++;
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents n words; optional idle cycle after each word
    task automatic load_words(input int n, input bit with_last, input bit gaps);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_addr  = prog_addr[i];
            ld_data  = prog_data[i];
            ld_last  = with_last && (i == n - 1);
            tick();
            if (gaps && i != n - 1) begin
                ld_valid = 1'b0;
                ld_last  = 1'b0;
                ld_data  = 32'hdead_beef;
                tick();
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic set_mips_prog();
        logic [DW-1:0] words [0:7];
        words = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                  32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
        for (int i = 0; i < 8; i++) begin
            prog_addr[i] = AW'(i);
            prog_data[i] = words[i];
        end
    endtask

    // Halts the core at RUN cycle k; called while in BOOT
    task automatic run_and_halt(input int k);
        tick();
        ticks(k - 1);
        cpu_halted = 1'b1;
        tick();
        cpu_halted = 1'b0;
    endtask

    initial begin
        // Reset state
        ticks(3);
        chk("rst_ld_ready", 64'(ld_ready), 64'(0));
        chk("rst_cpu_run",  64'(cpu_run),  64'(0));
        chk("rst_run_cyc",  64'(run_cycles), 64'(0));
        rst = 1'b0;
        ticks(2);

        // Eight-word program, halt at RUN cycle 30
        set_mips_prog();
        obs_writes = 0; obs_pcloads = 0;
        do_start();
        load_words(8, 1'b1, 1'b0);
        run_and_halt(30);
        chk("prog_done",    64'(done),       64'(1));
        chk("prog_cycles",  64'(run_cycles), 64'(30));
        chk("prog_cpu_run", 64'(cpu_run),    64'(0));
        chk("prog_writes",  64'(obs_writes), 64'(8));
        chk("prog_pcloads", 64'(obs_pcloads), 64'(1));
        ticks(2);

        // Timeout with a core that never halts
        prog_addr[0] = 3'd4; prog_data[0] = 32'h1111_2222;
        prog_addr[1] = 3'd5; prog_data[1] = 32'h3333_4444;
        do_start();
        load_words(2, 1'b1, 1'b0);
        for (int n = 0; n < 300 && !err; n++) tick();
        chk("tmo_err",     64'(err),        64'(1));
        chk("tmo_code",    64'(err_code),   64'(2'b10));
        chk("tmo_cycles",  64'(run_cycles), 64'(127));
        chk("tmo_cpu_run", 64'(cpu_run),    64'(0));
        ticks(2);

        // Overflow: nine words without a last marker
        for (int i = 0; i < 9; i++) begin
            prog_addr[i] = AW'(i);
            prog_data[i] = 32'h0100_0000 + 32'(i);
        end
        obs_writes = 0; obs_pcloads = 0;
        do_start();
        chk("ovf_cleared", 64'(err), 64'(0));
        load_words(9, 1'b0, 1'b0);
        ticks(2);
        chk("ovf_writes",  64'(obs_writes),  64'(8));
        chk("ovf_code",    64'(err_code),    64'(2'b01));
        chk("ovf_pcloads", 64'(obs_pcloads), 64'(0));

        // Valid toggling every cycle, scattered addresses
        prog_addr[0] = 3'd5; prog_addr[1] = 3'd2; prog_addr[2] = 3'd7;
        prog_addr[3] = 3'd0; prog_addr[4] = 3'd3; prog_addr[5] = 3'd1;
        for (int i = 0; i < 6; i++) prog_data[i] = $urandom;
        obs_writes = 0;
        do_start();
        load_words(6, 1'b1, 1'b1);
        run_and_halt(1);
        chk("gap_writes", 64'(obs_writes), 64'(6));
        chk("gap_cycles", 64'(run_cycles), 64'(1));

        // Asynchronous reset mid-load, then a clean reload
        set_mips_prog();
        do_start();
        load_words(3, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ld_ready", 64'(ld_ready), 64'(0));
        chk("arst_mem_we",   64'(mem_we),   64'(0));
        chk("arst_err_code", 64'(err_code), 64'(0));
        tick();
        rst = 1'b0;
        ld_valid = 1'b1; ld_addr = 3'd6; ld_data = 32'hbad0_0bad;
        ticks(2);
        ld_valid = 1'b0;
        obs_writes = 0; obs_pcloads = 0;
        do_start();
        load_words(8, 1'b1, 1'b0);
        run_and_halt(5);
        chk("reload_writes", 64'(obs_writes), 64'(8));
        chk("reload_cycles", 64'(run_cycles), 64'(5));
        chk("reload_done",   64'(done),       64'(1));

        // Start pulsed during RUN is ignored
        do_start();
        load_words(4, 1'b1, 1'b0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(3);
        cpu_halted = 1'b1;
        tick();
        cpu_halted = 1'b0;
        ticks(3);
        chk("ign_done",     64'(done),       64'(1));
        chk("ign_ld_ready", 64'(ld_ready),   64'(0));
        chk("ign_cycles",   64'(run_cycles), 64'(5));

        ticks(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_boot_loader.md
MIPS_BOOT_LOADER -- requirements
Module: mips_boot_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning instruction/data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 10, meaning memory address width; program depth limit DEPTH = 2^ADDR_W words.
REQ-003 The block SHALL have parameter TMO_W, default 16, meaning run-cycle counter width; timeout at 2^TMO_W-1 cycles.
REQ-004 The block SHALL have parameter BOOT_PC, default 0, meaning PC value driven at processor release.
REQ-005 The block SHALL have port clk1  input  1  single clock, all state on rising edge.
REQ-006 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port start  input  1  begin load session (sampled in IDLE, DONE, ERR only).
REQ-008 The block SHALL have ports ld_valid input 1, ld_ready output 1, ld_addr input ADDR_W, ld_data input DATA_W, ld_last input 1: program-word stream.
REQ-009 The block SHALL have ports mem_we output 1, mem_addr output ADDR_W, mem_wdata output DATA_W: memory write port.
REQ-010 The block SHALL have ports pc_load output 1 and pc_init output DATA_W: PC initialisation strobe/value.
REQ-011 The block SHALL have ports cpu_run output 1 (processor released, HALTED deasserted) and cpu_halted input 1 (processor executed HLT).
REQ-012 The block SHALL have outputs done 1, err 1, err_code 2 (01 overflow, 10 timeout), run_cycles TMO_W.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, BOOT, RUN, DONE, ERR.
REQ-014 IDLE/DONE/ERR: start=1 -> LOAD; same edge clears done, err, err_code, word counter.
REQ-015 LOAD: ld_ready=1; word accepted on cycle with ld_valid&ld_ready; ld_ready=0 in all other states.
REQ-016 Each accepted word SHALL produce mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data registered one cycle later, mem_we one cycle wide per word; back-to-back words give consecutive write cycles.
REQ-017 Accepting a word with ld_last=1 SHALL move LOAD -> BOOT.
REQ-018 Word counter increments per accepted word; accepting word number DEPTH+1 without a prior ld_last SHALL not write memory, go to ERR, err_code=01.
REQ-019 BOOT: lasts exactly one cycle, pc_load=1, pc_init=BOOT_PC, then -> RUN; pc_init holds BOOT_PC in all states.
REQ-020 RUN: cpu_run=1; run_cycles cleared to 0 on entry, +1 per cycle, saturating.
REQ-021 RUN with cpu_halted=1 -> DONE, done=1, cpu_run=0 next cycle, run_cycles frozen.
REQ-022 RUN with run_cycles reaching 2^TMO_W-1 and cpu_halted=0 -> ERR, err_code=10, cpu_run=0.
REQ-023 Simultaneous halt and timeout SHALL resolve as DONE.
REQ-024 start SHALL be ignored in LOAD, BOOT, RUN.
REQ-025 done, err, err_code, run_cycles SHALL hold in DONE/ERR until next start or reset.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, ld_ready=0, mem_we=0, pc_load=0, cpu_run=0, done=0, err=0, err_code=00, run_cycles=0, word counter=0, regardless of state (including mid-LOAD or mid-RUN).
REQ-027 After rst release, first accepted action SHALL be start in IDLE; no memory write occurs before it.

Verification
REQ-028 Load 8 words (0x28010078, 0x0c631800, 0x20220000, 0x0c631800, 0x2842002d, 0x0c631800, 0x24220001, 0xfc000000, last on 8th), cpu_halted at 30th RUN cycle -> 8 mem_we pulses addr 0..7, one pc_load with pc_init=0, done=1, run_cycles=30.
REQ-029 TMO_W=7, cpu_halted never -> err=1, err_code=10, run_cycles=127, cpu_run=0.
REQ-030 ADDR_W=3, 9 words, no ld_last -> exactly 8 writes, err_code=01, no pc_load.
REQ-031 ld_valid toggling 1/0 every cycle during LOAD -> writes only for valid cycles, data/address match, order preserved.
REQ-032 rst asserted after 3 of 8 words -> all outputs at reset values asynchronously; fresh start reloads 8 words cleanly.
REQ-033 start pulsed during RUN, then halt -> start ignored, done=1, state stays DONE.
